// File: rtl/parity_pkg.sv
// Shared definitions for the parity serial transmitter: FSM encoding and
// default frame geometry.
package parity_pkg;

   localparam int DEF_DATA_W       = 3;
   localparam int DEF_CLKS_PER_BIT = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

endpackage

// File: rtl/evenparity.sv
// Even-parity generator: the output makes the total count of ones
// (data plus parity) even.
module evenparity #(
   parameter int W = 8
) (
   input  logic [W-1:0] data,
   output logic         parity
);

   assign parity = ^data;

endmodule

// File: rtl/parity_serial_tx.sv
// Serial transmitter: sends each accepted message as a start bit, LSB-first
// data bits, an even-parity bit and a stop bit, each CLKS_PER_BIT cycles long.
module parity_serial_tx
   import parity_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              msg_valid,
   input  logic [DATA_W-1:0] message,
   output logic              msg_ready,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [3:0] IDX_LAST = 4'(DATA_W - 1);

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [3:0]        idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic              par_s;

   // Selects data bit i without an out-of-range index for small DATA_W.
   function automatic logic bit_at(input logic [DATA_W-1:0] d, input logic [3:0] i);
      logic b;
      b = 1'b0;
      for (int k = 0; k < DATA_W; k++) begin
         b = (int'(i) == k) ? d[k] : b;
      end
      return b;
   endfunction

   evenparity #(.W(DATA_W)) u_evenparity (
      .data   (message),
      .parity (par_s)
   );

   // Next-state, counter and output decode; outputs follow the next state
   // so every output comes straight from a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      par_d   = par_q;
      case (state_q)
         IDLE: begin
            if (msg_valid) begin
               state_d = START;
               data_d  = message;
               par_d   = par_s;
               cnt_d   = 8'd0;
               idx_d   = 4'd0;
            end else begin
               cnt_d   = 8'd0;
               idx_d   = 4'd0;
            end
         end
         START: begin
            if (cnt_q == CNT_LAST) begin
               state_d = DATA;
               cnt_d   = 8'd0;
               idx_d   = 4'd0;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = 8'd0;
               if (idx_q == IDX_LAST) begin
                  state_d = PARITY;
                  idx_d   = 4'd0;
               end else begin
                  idx_d   = idx_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         PARITY: begin
            if (cnt_q == CNT_LAST) begin
               state_d = STOP;
               cnt_d   = 8'd0;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
            idx_d   = 4'd0;
         end
      endcase

      case (state_d)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = bit_at(data_d, idx_d);
         PARITY:  tx_d = par_d;
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase

      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE);
      done_d  = (state_d == STOP) && (cnt_d == CNT_LAST);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         idx_q   <= 4'd0;
         data_q  <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   assign msg_ready  = ready_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Self-checking bench for parity_serial_tx: table-driven frames through a
// scoreboard on a CLKS_PER_BIT=4 instance, plus a CLKS_PER_BIT=1 instance.
module tb_parity_serial_tx;

   localparam int W    = 3;
   localparam int CPB  = 4;
   localparam int FLEN = (W + 3) * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       msg_valid_a = 1'b0;
   logic [2:0] message_a = 3'd0;
   logic       msg_ready_a, tx_a, busy_a, frame_done_a;
   logic       msg_valid_b = 1'b0;
   logic [2:0] message_b = 3'd0;
   logic       msg_ready_b, tx_b, busy_b, frame_done_b;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int frames_seen = 0;
   int abort_cnt = 0;
   logic [5:0] exp_q[$];
   int starts_q[$];

   typedef struct {
      logic [2:0] msg;
      logic [5:0] bits;
   } vec_t;
   vec_t vecs[4];

   parity_serial_tx #(.DATA_W(W), .CLKS_PER_BIT(CPB)) dut_a (
      .clk(clk), .rst(rst), .msg_valid(msg_valid_a), .message(message_a),
      .msg_ready(msg_ready_a), .tx(tx_a), .busy(busy_a), .frame_done(frame_done_a)
   );

   parity_serial_tx #(.DATA_W(W), .CLKS_PER_BIT(1)) dut_b (
      .clk(clk), .rst(rst), .msg_valid(msg_valid_b), .message(message_b),
      .msg_ready(msg_ready_b), .tx(tx_b), .busy(busy_b), .frame_done(frame_done_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bit k of the result is the tx level in bit period k of the frame.
   function automatic logic [5:0] bits6(input logic p0, input logic p1, input logic p2,
                                        input logic p3, input logic p4, input logic p5);
      return {p5, p4, p3, p2, p1, p0};
   endfunction

   function automatic logic [5:0] model(input logic [2:0] m);
      return bits6(1'b0, m[0], m[1], m[2], m[0] ^ m[1] ^ m[2], 1'b1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Frame monitor: captures tx per cycle, checks length and bits at frame_done.
   logic [FLEN-1:0] samp;
   int fcyc = 0;
   bit in_frame = 1'b0;
   always @(negedge clk) begin
      if (!in_frame && busy_a) begin
         in_frame = 1'b1;
         fcyc = 0;
         samp = '0;
         starts_q.push_back(cyc);
      end
      if (in_frame) begin
         if (busy_a) begin
            chk("ready_low_in_frame", msg_ready_a, 1'b0);
            if (fcyc < FLEN) samp[fcyc] = tx_a;
            fcyc++;
            if (frame_done_a) begin
               logic [FLEN-1:0] ex;
               logic [5:0] e;
               chk("frame_length", fcyc, FLEN);
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", 1'b1, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  for (int c = 0; c < FLEN; c++) ex[c] = e[c / CPB];
                  chk("frame_bits", samp, ex);
               end
               frames_seen++;
               in_frame = 1'b0;
            end else if (fcyc > FLEN) begin
               chk("frame_overrun", fcyc, FLEN);
               in_frame = 1'b0;
            end
         end else begin
            abort_cnt++;
            in_frame = 1'b0;
         end
      end else if (frame_done_a) begin
         chk("stray_frame_done", frame_done_a, 1'b0);
      end
   end

   task automatic wait_ready_a();
      int t = 0;
      while (!msg_ready_a && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("ready_timeout", 1'b0, 1'b1);
   endtask

   task automatic send_a(input logic [2:0] m, input logic [5:0] e);
      wait_ready_a();
      msg_valid_a = 1'b1;
      message_a   = m;
      exp_q.push_back(e);
      @(negedge clk);
      msg_valid_a = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      int t = 0;
      while (frames_seen < n && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) chk("frame_timeout", frames_seen, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nf, sz0;
      logic [2:0] seq_b;
      vecs[0] = '{3'b001, bits6(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1)};
      vecs[1] = '{3'b111, bits6(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1)};
      vecs[2] = '{3'b110, bits6(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1)};
      vecs[3] = '{3'b000, bits6(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};

      repeat (3) @(negedge clk);
      chk("rst_tx", tx_a, 1'b1);
      chk("rst_ready", msg_ready_a, 1'b1);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", frame_done_a, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Fixed vectors, one frame at a time.
      for (int i = 0; i < 4; i++) begin
         nf = frames_seen;
         send_a(vecs[i].msg, vecs[i].bits);
         wait_frames(nf + 1);
      end

      // Back-to-back sweep with msg_valid held high.
      nf  = frames_seen;
      sz0 = starts_q.size();
      msg_valid_a = 1'b1;
      for (int m = 0; m < 8; m++) begin
         wait_ready_a();
         message_a = m[2:0];
         exp_q.push_back(model(m[2:0]));
         @(negedge clk);
      end
      msg_valid_a = 1'b0;
      wait_frames(nf + 8);
      for (int i = 1; i < 8; i++) begin
         if (sz0 + i < starts_q.size())
            chk("start_gap", starts_q[sz0 + i] - starts_q[sz0 + i - 1], 25);
         else
            chk("start_missing", starts_q.size(), sz0 + 8);
      end

      // Input changes mid-frame must be ignored.
      nf = frames_seen;
      send_a(3'b010, model(3'b010));
      repeat (8) @(negedge clk);
      message_a   = 3'b111;
      msg_valid_a = 1'b1;
      chk("ready_mid_frame", msg_ready_a, 1'b0);
      @(negedge clk);
      msg_valid_a = 1'b0;
      chk("ready_mid_frame2", msg_ready_a, 1'b0);
      wait_frames(nf + 1);
      repeat (40) @(negedge clk);
      chk("no_extra_frame", frames_seen, nf + 1);
      chk("queue_drained", exp_q.size(), 0);

      // Reset at frame cycle 10, with a request pending during reset.
      nf = frames_seen;
      send_a(3'b011, model(3'b011));
      repeat (9) @(negedge clk);
      rst         = 1'b1;
      msg_valid_a = 1'b1;
      message_a   = 3'b101;
      @(negedge clk);
      rst         = 1'b0;
      msg_valid_a = 1'b0;
      chk("abort_tx", tx_a, 1'b1);
      chk("abort_busy", busy_a, 1'b0);
      chk("abort_ready", msg_ready_a, 1'b1);
      chk("abort_done", frame_done_a, 1'b0);
      exp_q.delete();
      repeat (30) @(negedge clk);
      chk("abort_count", abort_cnt, 1);
      chk("abort_no_frame", frames_seen, nf);
      send_a(3'b100, model(3'b100));
      wait_frames(nf + 1);
      chk("post_reset_queue", exp_q.size(), 0);

      // One clock per bit: six consecutive tx values.
      seq_b = 3'b101;
      chk("b_ready_idle", msg_ready_b, 1'b1);
      msg_valid_b = 1'b1;
      message_b   = seq_b;
      @(negedge clk);
      msg_valid_b = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk("b_tx", tx_b, model(seq_b)[k]);
         chk("b_done", frame_done_b, (k == 5) ? 1'b1 : 1'b0);
         chk("b_busy", busy_b, 1'b1);
         @(negedge clk);
      end
      chk("b_idle_busy", busy_b, 1'b0);
      chk("b_idle_ready", msg_ready_b, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/parity_serial_tx.md
PARITY_SERIAL_TX -- requirements
Module: parity_serial_tx

Interface
REQ-001 Parameter DATA_W, default 3, message width in bits (legal 1..16).
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit period (legal 1..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 msg_valid  input  1  requester has a message to send.
REQ-006 message  input  DATA_W  message word, sampled when msg_valid and msg_ready are both high.
REQ-007 msg_ready  output  1  block can accept a message this cycle.
REQ-008 tx  output  1  serial line; idle level 1.
REQ-009 busy  output  1  a frame is in progress (state is not IDLE).
REQ-010 frame_done  output  1  one-cycle pulse marking the last cycle of a frame.

Function
REQ-011 The block SHALL sequence the even-parity generator: each accepted message is sent as one serial frame with its even-parity bit appended.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-013 msg_ready SHALL equal 1 only in IDLE; a handshake occurs when msg_valid and msg_ready are both 1 on a rising edge.
REQ-014 On a handshake the block SHALL latch message and parity = XOR of all message bits (total count of ones even), and enter START at that edge.
REQ-015 msg_valid and message SHALL be ignored outside IDLE; a latched message SHALL NOT change mid-frame.
REQ-016 Each of START, every DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a bit-period counter.
REQ-017 tx SHALL be 0 in START, message bit i in the i-th DATA period (LSB first, i = 0..DATA_W-1, tracked by a bit-index counter), parity in PARITY, 1 in STOP and IDLE.
REQ-018 A frame SHALL occupy exactly (DATA_W+3)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-019 frame_done SHALL be 1 in the final STOP cycle only; the FSM SHALL return to IDLE on the next edge.
REQ-020 With msg_valid held high, back-to-back frames SHALL be separated by exactly one IDLE cycle (tx = 1, msg_ready = 1).
REQ-021 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-022 The bit-period and bit-index counters SHALL reset to 0 at each state transition and SHALL NOT wrap within a state.

Reset
REQ-023 While rst is high, the next edge SHALL force state IDLE, tx = 1, msg_ready = 1, busy = 0, frame_done = 0, and all counters and latched data to 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no frame_done; no partial resend after reset.
REQ-025 A handshake SHALL NOT be taken in a cycle where rst is high.

Structure
REQ-026 Package parity_pkg SHALL hold the FSM state enumeration and the default DATA_W and CLKS_PER_BIT constants.
REQ-027 Parity SHALL be computed by one instance of the existing evenparity sub-module, widened to DATA_W, driven from the input message at handshake.
REQ-028 Counters and FSM SHALL stay in parity_serial_tx; no other sub-modules.

Verification
REQ-029 DATA_W=3, CLKS_PER_BIT=4, message=3'b001: tx over 6 bit periods = 0,1,0,0,1,1 (parity 1), frame_done at cycle 24 of the frame.
REQ-030 message=3'b111 -> 0,1,1,1,1,1; message=3'b110 -> 0,0,1,1,0,1; message=3'b000 -> 0,0,0,0,0,1.
REQ-031 Sweep message 0..7 with msg_valid held high: each parity bit equals XOR of the message bits; frame starts exactly 25 cycles apart.
REQ-032 Change message and pulse msg_valid during DATA of a frame: frame bits unchanged, msg_ready stays 0, no extra frame.
REQ-033 Assert rst at cycle 10 of a frame: next cycle tx = 1, busy = 0, msg_ready = 1, no frame_done; a new message then sends a correct full frame.
REQ-034 CLKS_PER_BIT=1, message=3'b101: six consecutive tx values 0,1,0,1,0,1, frame_done in the sixth cycle.
